dma_fifo: RTL and testbench
===========================

Name: dma_fifo

Overview:
- Synchronous single-clock FIFO that buffers 16-bit words between a peripheral and the MSP430 memory port inside the DMA controller.
- One shared enable plus a direction select (write or read), so only one operation happens per cycle.
- A rollback flag undoes the last transfer when the memory bus stalls.
- A partial-empty flag tells the controller when to resume filling after a full condition.

Parameters:
- DATA, 16, word width in bits.
- ADDR_SIZE, 5, pointer width; DEPTH = 2^ADDR_SIZE entries (32).
- DIV_FACTOR, 3; partial-empty threshold = DEPTH >> DIV_FACTOR (4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rst  input  1  synchronous clear of pointers, occupancy and flags.
- fifo_enable  input  1  perform the operation selected by fifo_wr_rd this cycle.
- fifo_wr_rd  input  1  1 = write (push), 0 = read (pop).
- fifo_old_add_flag  input  1  roll back the last operation in the fifo_wr_rd direction.
- fifo_in  input  DATA  write data.
- fifo_out  output  DATA  word at read pointer (first-word fall-through).
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- empty_partial  output  1  occupancy <= DEPTH >> DIV_FACTOR.

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_SIZE bits, wrap modulo DEPTH), occupancy (ADDR_SIZE+1 bits), flag_q (registered fifo_old_add_flag), storage array DEPTH x DATA.
- Async reset: pointers, occupancy and flag_q are 0, and every storage word is 0. After reset: fifo_out = 0, empty = 1, empty_partial = 1, full = 0.
- rst (sync, priority over all other inputs): pointers, occupancy and flag_q are 0 at the next edge. Storage is not cleared. rst is ignored while reset is high.
- Push (fifo_enable=1, fifo_wr_rd=1, fifo_old_add_flag=0):
  - if not full: mem[wr_ptr] <= fifo_in, wr_ptr+1, occupancy+1.
  - if full: no change.
- Pop (fifo_enable=1, fifo_wr_rd=0, fifo_old_add_flag=0):
  - if not empty: rd_ptr+1, occupancy-1.
  - if empty: no change.
- fifo_out = mem[rd_ptr], combinational. It changes in the cycle after a pop edge or a rollback edge.
- Rollback fires on the first cycle that fifo_old_add_flag is high (flag high and flag_q low). fifo_enable is ignored while the flag is high.
  - fifo_wr_rd=1, occupancy > 0: wr_ptr-1, occupancy-1. The next push overwrites the stale word.
  - fifo_wr_rd=0, occupancy < DEPTH: rd_ptr-1, occupancy+1. fifo_out re-presents the previously popped word.
  - Rollback saturates: no action when the bound would be violated.
- While fifo_old_add_flag stays high after the first cycle: pointers, occupancy and storage hold. There is exactly one rollback per assertion.
- flag_q <= fifo_old_add_flag every cycle.
- Flags are combinational from occupancy. They update the cycle after the causing edge.
- Pointer wrap: DEPTH-1 goes to 0 on increment, and 0 goes to DEPTH-1 on rollback.

Decomposition:
- Package dma_pkg: DATA_LEN=16, ADDR_LEN=16, FIFO_DEPTH=5, FIFO_DIV_FACTOR=3, and a function deriving DEPTH and the partial threshold.
- One sub-module, dma_fifo_mem: DEPTH x DATA storage with synchronous write, combinational read and async clear on reset.
- Pointer, occupancy and flag logic stay in dma_fifo.

Test Plan:
- Reset, then push 0x0001..0x0020 (32 words): full=1 after the 32nd edge. A 33rd push of 0xFFFF is ignored; occupancy stays 32 and mem[0] is still 0x0001.
- From full, pop 28 times: empty_partial rises when occupancy reaches 4. fifo_out steps 0x0001..0x001C, then shows 0x001D. Pop 4 more: empty=1.
- Push 0xA, 0xB, then hold fifo_old_add_flag=1 with fifo_wr_rd=1 for 3 cycles: occupancy goes 2 to 1 once only. Next push 0xC, then two pops give 0xA, 0xC.
- Pop 0xA from {0xA,0xB}, then assert the flag with fifo_wr_rd=0 and fifo_enable=1 for 2 cycles: fifo_out returns to 0xA and occupancy is 2.
- Wrap: after 32 push/pop pairs, push 0x1234 and pop: data is correct at pointer 0 and empty=1.
- Mid-fill: rst=1 for one cycle after 10 pushes gives empty=1, full=0, occupancy 0. Async reset asserted mid-cycle clears immediately, with fifo_out=0.

Source files
------------

// File: rtl/dma_fifo_pkg.sv
// dma_pkg: shared constants and sizing helpers for the DMA controller FIFO.
//   DATA_LEN        word width
//   ADDR_LEN        DMA address width
//   FIFO_DEPTH      FIFO pointer width (entries = 2**FIFO_DEPTH)
//   FIFO_DIV_FACTOR shift applied to the entry count for the partial-empty threshold
package dma_pkg;
  localparam int DATA_LEN        = 16;
  localparam int ADDR_LEN        = 16;
  localparam int FIFO_DEPTH      = 5;
  localparam int FIFO_DIV_FACTOR = 3;

  function automatic int fifo_entries(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic int fifo_partial(input int addr_size, input int div_factor);
    return (1 << addr_size) >> div_factor;
  endfunction
endpackage

// File: rtl/dma_fifo_if.sv
// dma_fifo_if: handshake/data bundle between the DMA controller and its FIFO.
//   master: controller side (drives enable, direction, rollback flag, write data)
//   slave : FIFO side (drives read data and status flags)
interface dma_fifo_if #(parameter int DATA = dma_pkg::DATA_LEN);
  logic            fifo_enable;
  logic            fifo_wr_rd;
  logic            fifo_old_add_flag;
  logic [DATA-1:0] fifo_in;
  logic [DATA-1:0] fifo_out;
  logic            full;
  logic            empty;
  logic            empty_partial;

  modport master (
    output fifo_enable, fifo_wr_rd, fifo_old_add_flag, fifo_in,
    input  fifo_out, full, empty, empty_partial
  );
  modport slave (
    input  fifo_enable, fifo_wr_rd, fifo_old_add_flag, fifo_in,
    output fifo_out, full, empty, empty_partial
  );
endinterface

// File: rtl/dma_fifo_mem.sv
// dma_fifo_mem: DEPTH x DATA register-file storage.
//   clk, reset : clock, async active-high clear of every word
//   i_we       : write strobe, i_waddr/i_wdata written at the rising edge
//   i_raddr    : read address, o_rdata is combinational (fall-through)
module dma_fifo_mem
  import dma_pkg::*;
#(
  parameter int DATA      = DATA_LEN,
  parameter int ADDR_SIZE = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA-1:0]      i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA-1:0]      o_rdata
);
  localparam int DEPTH = fifo_entries(ADDR_SIZE);

  logic [DEPTH-1:0][DATA-1:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_mem          <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dma_fifo.sv
// dma_fifo: single-clock word FIFO between a peripheral and the memory port.
//   clk, reset : clock, async active-high reset (also clears storage)
//   rst        : sync clear of pointers, occupancy and rollback edge detector
//   bus        : dma_fifo_if.slave
//     fifo_enable/fifo_wr_rd : one push (1) or pop (0) per enabled cycle
//     fifo_old_add_flag      : undo the last op in the fifo_wr_rd direction
//     fifo_out               : word at read pointer, fall-through
//     full/empty/empty_partial : occupancy status
module dma_fifo
  import dma_pkg::*;
#(
  parameter int DATA       = DATA_LEN,
  parameter int ADDR_SIZE  = FIFO_DEPTH,
  parameter int DIV_FACTOR = FIFO_DIV_FACTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rst,
  dma_fifo_if.slave   bus
);
  localparam int DEPTH = fifo_entries(ADDR_SIZE);
  localparam int PART  = fifo_partial(ADDR_SIZE, DIV_FACTOR);
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] PART_C  = (ADDR_SIZE+1)'(PART);

  logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_SIZE:0]   r_occ;
  logic                 r_flag_q;

  logic w_full, w_empty, w_roll, w_push, w_pop, w_rb_wr, w_rb_rd;

  assign w_full  = (r_occ == DEPTH_C);
  assign w_empty = (r_occ == '0);

  // Rollback acts only on the rising edge of the flag; while the flag is
  // held, normal enables are suppressed so the FIFO simply holds.
  assign w_roll  = bus.fifo_old_add_flag & ~r_flag_q;
  assign w_push  = bus.fifo_enable & bus.fifo_wr_rd  & ~bus.fifo_old_add_flag & ~w_full;
  assign w_pop   = bus.fifo_enable & ~bus.fifo_wr_rd & ~bus.fifo_old_add_flag & ~w_empty;
  assign w_rb_wr = w_roll & bus.fifo_wr_rd  & ~w_empty;
  assign w_rb_rd = w_roll & ~bus.fifo_wr_rd & ~w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_flag_q <= 1'b0;
    end else if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_flag_q <= 1'b0;
    end else begin
      r_flag_q <= bus.fifo_old_add_flag;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_occ    <= r_occ + 1'b1;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_occ    <= r_occ - 1'b1;
      end else if (w_rb_wr) begin
        r_wr_ptr <= r_wr_ptr - 1'b1;
        r_occ    <= r_occ - 1'b1;
      end else if (w_rb_rd) begin
        r_rd_ptr <= r_rd_ptr - 1'b1;
        r_occ    <= r_occ + 1'b1;
      end
    end
  end

  dma_fifo_mem #(.DATA(DATA), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_push & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.fifo_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.fifo_out)
  );

  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.empty_partial = (r_occ <= PART_C);
endmodule

// File: tb/tb_dma_fifo.sv
// tb_dma_fifo: directed vector bench for dma_fifo.
module tb_dma_fifo;
  logic clk = 1'b0;
  logic reset, rst;
  dma_fifo_if bus();

  dma_fifo dut (.clk(clk), .reset(reset), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, en, wr, flag;
    logic [15:0] din;
    logic        chk;
    logic [15:0] out;
    logic [2:0]  fl;   // {full, empty, empty_partial}
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input string nm, input logic r, e, w, f, input logic [15:0] d,
                     input logic c, input logic [15:0] o, input logic fu, em, pa);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.wr = w; v.flag = f; v.din = d;
    v.chk = c; v.out = o; v.fl = {fu, em, pa};
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, e, w, f, input logic [15:0] d);
    rst = r; bus.fifo_enable = e; bus.fifo_wr_rd = w;
    bus.fifo_old_add_flag = f; bus.fifo_in = d;
  endtask

  initial begin
    drive(0, 0, 0, 0, 16'h0);
    reset = 1'b1;

    // fill 1..32, then an ignored push at full
    for (int k = 1; k <= 32; k++)
      add("fill", 0, 1, 1, 0, 16'(k), 1, 16'h0001, k == 32, 0, k <= 4);
    add("push_full", 0, 1, 1, 0, 16'hFFFF, 1, 16'h0001, 1, 0, 0);
    // drain; wrapped rd_ptr shows mem[0] again
    for (int j = 1; j <= 32; j++)
      add("drain", 0, 1, 0, 0, 16'h0, 1, (j == 32) ? 16'h0001 : 16'(j + 1),
          0, j == 32, (32 - j) <= 4);
    // write rollback held 3 cycles: exactly one undo
    add("rbw_pushA", 0, 1, 1, 0, 16'h000A, 1, 16'h000A, 0, 0, 1);
    add("rbw_pushB", 0, 1, 1, 0, 16'h000B, 1, 16'h000A, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      add("rbw_hold", 0, 1, 1, 1, 16'hEEEE, 1, 16'h000A, 0, 0, 1);
    add("rbw_pushC", 0, 1, 1, 0, 16'h000C, 1, 16'h000A, 0, 0, 1);
    add("rbw_pop1",  0, 1, 0, 0, 16'h0,    1, 16'h000C, 0, 0, 1);
    add("rbw_pop2",  0, 1, 0, 0, 16'h0,    1, 16'h0003, 0, 1, 1);
    // read rollback, enable held high to prove it is ignored
    add("rbr_pushA", 0, 1, 1, 0, 16'h000A, 1, 16'h000A, 0, 0, 1);
    add("rbr_pushB", 0, 1, 1, 0, 16'h000B, 1, 16'h000A, 0, 0, 1);
    add("rbr_pop",   0, 1, 0, 0, 16'h0,    1, 16'h000B, 0, 0, 1);
    add("rbr_flag1", 0, 1, 0, 1, 16'h0,    1, 16'h000A, 0, 0, 1);
    add("rbr_flag2", 0, 1, 0, 1, 16'h0,    1, 16'h000A, 0, 0, 1);
    add("rbr_idle",  0, 0, 0, 0, 16'h0,    1, 16'h000A, 0, 0, 1);
    add("rbr_pop1",  0, 1, 0, 0, 16'h0,    1, 16'h000B, 0, 0, 1);
    add("rbr_pop2",  0, 1, 0, 0, 16'h0,    1, 16'h0005, 0, 1, 1);
    // push/pop pairs from pointer 4 across the 31->0 wrap
    for (int i = 0; i < 28; i++) begin
      add("wrap_push", 0, 1, 1, 0, 16'(16'h0100 + i), 1, 16'(16'h0100 + i), 0, 0, 1);
      add("wrap_pop",  0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1);
    end
    // read rollback 0 -> 31, then saturated write rollback on empty
    add("rb_wrap",   0, 0, 0, 1, 16'h0, 1, 16'h011B, 0, 0, 1);
    add("rb_idle",   0, 0, 0, 0, 16'h0, 1, 16'h011B, 0, 0, 1);
    add("rb_pop",    0, 1, 0, 0, 16'h0, 1, 16'h000A, 0, 1, 1);
    add("rb_sat",    0, 0, 1, 1, 16'h0, 1, 16'h000A, 0, 1, 1);
    add("rb_idle2",  0, 0, 0, 0, 16'h0, 1, 16'h000A, 0, 1, 1);
    add("p0_push",   0, 1, 1, 0, 16'h1234, 1, 16'h1234, 0, 0, 1);
    add("p0_pop",    0, 1, 0, 0, 16'h0, 1, 16'h000C, 0, 1, 1);
    // mid-fill sync clear, concurrent push must not land
    for (int k = 1; k <= 10; k++)
      add("mid_push", 0, 1, 1, 0, 16'(16'h01FF + k), 1, 16'h0200, 0, 0, k <= 4);
    add("sync_rst",  1, 1, 1, 0, 16'hDEAD, 1, 16'h1234, 0, 1, 1);
    add("post_pop",  0, 1, 0, 0, 16'h0,    1, 16'h1234, 0, 1, 1);
    add("post_push", 0, 1, 1, 0, 16'h0055, 1, 16'h0055, 0, 0, 1);
    add("push2",     0, 1, 1, 0, 16'h0066, 1, 16'h0055, 0, 0, 1);

    // reset state
    #12;
    check("reset_out", 32'(bus.fifo_out), 32'h0);
    check("reset_flags", 32'({bus.full, bus.empty, bus.empty_partial}), 32'b011);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].en, vq[i].wr, vq[i].flag, vq[i].din);
      @(posedge clk);
      #1;
      check({vq[i].name, "_flags"}, 32'({bus.full, bus.empty, bus.empty_partial}), 32'(vq[i].fl));
      if (vq[i].chk) check({vq[i].name, "_out"}, 32'(bus.fifo_out), 32'(vq[i].out));
    end

    // async reset mid-cycle clears without a clock edge
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0);
    #2 reset = 1'b1;
    #1;
    check("areset_out", 32'(bus.fifo_out), 32'h0);
    check("areset_flags", 32'({bus.full, bus.empty, bus.empty_partial}), 32'b011);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("areset_hold_out", 32'(bus.fifo_out), 32'h0);
    check("areset_hold_flags", 32'({bus.full, bus.empty, bus.empty_partial}), 32'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
